// File: rtl/scroll_refresh_ctrl_if.sv
// Handshake and scroll bus between the game FSM/world (master) and scroll_refresh_ctrl (slave).
interface scroll_refresh_ctrl_if #(
    parameter int HEIGHT_W = 20
);
    logic [2:0]          outstate;
    logic [9:0]          doodle_y;
    logic                doodle_rising;
    logic                refresh_en;
    logic                trigger;
    logic                scroll_step;
    logic [3:0]          scroll_dy;
    logic [HEIGHT_W-1:0] height;

    modport master (
        output outstate, doodle_y, doodle_rising,
        input  refresh_en, trigger, scroll_step, scroll_dy, height
    );

    modport slave (
        input  outstate, doodle_y, doodle_rising,
        output refresh_en, trigger, scroll_step, scroll_dy, height
    );
endinterface

// File: rtl/scroll_refresh_ctrl.sv
// Refresh responder: requests Refreshing when the doodle climbs high, scrolls one step per frame,
// then holds trigger until the FSM leaves Refreshing. All outputs registered; no backpressure.
module scroll_refresh_ctrl #(
    parameter int THRESH_Y   = 160,
    parameter int TARGET_Y   = 320,
    parameter int STEP       = 8,
    parameter int MAX_SCROLL = 240,
    parameter int HEIGHT_W   = 20
) (
    input  logic Clock,
    input  logic Reset,
    input  logic frame_clk,
    scroll_refresh_ctrl_if.slave bus
);
    localparam logic [2:0] OS_GAME    = 3'b010;
    localparam logic [2:0] OS_REFRESH = 3'b100;
    localparam logic [2:0] OS_INIT    = 3'b101;

    localparam logic [9:0] THRESH_10 = 10'(THRESH_Y);
    localparam logic [9:0] TARGET_10 = 10'(TARGET_Y);
    localparam logic [9:0] MAX_10    = 10'(MAX_SCROLL);
    localparam logic [9:0] STEP_10   = 10'(STEP);
    localparam logic [3:0] STEP_4    = 4'(STEP);

    typedef enum logic [1:0] {IDLE, ARMED, SCROLL, DONE} state_t;

    state_t              state_q, state_d;
    logic [9:0]          remaining_q, remaining_d;
    logic                refresh_en_q, refresh_en_d;
    logic                trigger_q, trigger_d;
    logic                scroll_step_q, scroll_step_d;
    logic [3:0]          scroll_dy_q, scroll_dy_d;
    logic [HEIGHT_W-1:0] height_q, height_d;
    logic                fclk_s1_q, fclk_s1_d;
    logic                fclk_s2_q, fclk_s2_d;
    logic                fclk_s3_q, fclk_s3_d;
    logic                frame_tick_q, frame_tick_d;

    logic [3:0]          step_dy;
    logic [9:0]          rem_after_step;
    logic [HEIGHT_W:0]   height_sum;
    logic [9:0]          capture_raw;
    logic [9:0]          capture_rem;

    assign step_dy        = (remaining_q < STEP_10) ? remaining_q[3:0] : STEP_4;
    assign rem_after_step = remaining_q - {6'd0, step_dy};
    assign height_sum     = {1'b0, height_q} + (HEIGHT_W+1)'(step_dy);
    // doodle_y < THRESH_Y < TARGET_Y at capture, so this never underflows
    assign capture_raw    = TARGET_10 - bus.doodle_y;
    assign capture_rem    = (capture_raw > MAX_10) ? MAX_10 : capture_raw;

    always_comb begin
        fclk_s1_d    = frame_clk;
        fclk_s2_d    = fclk_s1_q;
        fclk_s3_d    = fclk_s2_q;
        frame_tick_d = fclk_s2_q & ~fclk_s3_q;
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        refresh_en_d  = refresh_en_q;
        trigger_d     = trigger_q;
        scroll_step_d = 1'b0;
        scroll_dy_d   = scroll_dy_q;
        height_d      = height_q;

        case (state_q)
            IDLE: begin
                refresh_en_d = 1'b0;
                trigger_d    = 1'b0;
                if (bus.outstate == OS_GAME && bus.doodle_rising && bus.doodle_y < THRESH_10) begin
                    remaining_d  = capture_rem;
                    refresh_en_d = 1'b1;
                    state_d      = ARMED;
                end
            end
            ARMED: begin
                if (bus.outstate == OS_REFRESH) begin
                    refresh_en_d = 1'b0;
                    state_d      = SCROLL;
                end else if (bus.outstate != OS_GAME) begin
                    refresh_en_d = 1'b0;
                    remaining_d  = '0;
                    state_d      = IDLE;
                end
            end
            SCROLL: begin
                if (bus.outstate != OS_REFRESH) begin
                    remaining_d = '0;
                    state_d     = IDLE;
                end else if (frame_tick_q) begin
                    scroll_step_d = 1'b1;
                    scroll_dy_d   = step_dy;
                    remaining_d   = rem_after_step;
                    height_d      = height_sum[HEIGHT_W] ? '1 : height_sum[HEIGHT_W-1:0];
                    if (rem_after_step == 10'd0) begin
                        trigger_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.outstate != OS_REFRESH) begin
                    trigger_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // INIT wipes the climb and cancels any refresh in flight
        if (bus.outstate == OS_INIT) begin
            state_d       = IDLE;
            remaining_d   = '0;
            refresh_en_d  = 1'b0;
            trigger_d     = 1'b0;
            scroll_step_d = 1'b0;
            scroll_dy_d   = '0;
            height_d      = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            refresh_en_q  <= 1'b0;
            trigger_q     <= 1'b0;
            scroll_step_q <= 1'b0;
            scroll_dy_q   <= '0;
            height_q      <= '0;
            fclk_s1_q     <= 1'b0;
            fclk_s2_q     <= 1'b0;
            fclk_s3_q     <= 1'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            refresh_en_q  <= refresh_en_d;
            trigger_q     <= trigger_d;
            scroll_step_q <= scroll_step_d;
            scroll_dy_q   <= scroll_dy_d;
            height_q      <= height_d;
            fclk_s1_q     <= fclk_s1_d;
            fclk_s2_q     <= fclk_s2_d;
            fclk_s3_q     <= fclk_s3_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign bus.refresh_en  = refresh_en_q;
    assign bus.trigger     = trigger_q;
    assign bus.scroll_step = scroll_step_q;
    assign bus.scroll_dy   = scroll_dy_q;
    assign bus.height      = height_q;
endmodule

// File: tb/tb_scroll_refresh_ctrl.sv
// Scoreboard bench for scroll_refresh_ctrl: expected step sizes queued at stimulus, popped on scroll_step.
module tb_scroll_refresh_ctrl;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic frame_clk = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int step_cnt     = 0;
    logic [3:0] exp_q[$];

    scroll_refresh_ctrl_if #(.HEIGHT_W(20)) bus ();

    scroll_refresh_ctrl #(
        .THRESH_Y(160), .TARGET_Y(320), .STEP(8), .MAX_SCROLL(240), .HEIGHT_W(20)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (!Reset && bus.scroll_step === 1'b1) begin
            step_cnt++;
            if (exp_q.size() == 0)
                chk("spurious_step", {31'd0, bus.scroll_step}, 32'd0);
            else
                chk("step_dy", {28'd0, bus.scroll_dy}, {28'd0, exp_q.pop_front()});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic ftick();
        frame_clk = 1'b1;
        cyc(6);
        frame_clk = 1'b0;
        cyc(6);
    endtask

    // Reference: remaining = min(320-y, 240), then steps of min(8, remaining)
    task automatic push_steps(input int y, input int max_n);
        int rem;
        int n;
        rem = 320 - y;
        if (rem > 240) rem = 240;
        n = 0;
        while (rem > 0 && n < max_n) begin
            exp_q.push_back(4'((rem < 8) ? rem : 8));
            rem -= (rem < 8) ? rem : 8;
            n++;
        end
    endtask

    task automatic do_init();
        bus.outstate = 3'b101;
        cyc(1);
        bus.outstate = 3'b000;
        cyc(1);
    endtask

    task automatic request(input int y);
        bus.outstate      = 3'b010;
        bus.doodle_rising = 1'b1;
        bus.doodle_y      = 10'(y);
        cyc(1);
        bus.doodle_rising = 1'b0;
    endtask

    task automatic full_refresh(input int y, input int exp_steps, input int exp_height, input string nm);
        int start_cnt;
        do_init();
        request(y);
        chk({nm, "_refresh_en"}, {31'd0, bus.refresh_en}, 32'd1);
        push_steps(y, 1000);
        start_cnt = step_cnt;
        bus.outstate = 3'b100;
        cyc(1);
        chk({nm, "_refresh_en_drop"}, {31'd0, bus.refresh_en}, 32'd0);
        for (int i = 0; i < 40 && bus.trigger !== 1'b1; i++) ftick();
        chk({nm, "_trigger"}, {31'd0, bus.trigger}, 32'd1);
        chk({nm, "_steps"}, 32'(step_cnt - start_cnt), 32'(exp_steps));
        chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_height"}, 32'(bus.height), 32'(exp_height));
    endtask

    initial begin
        int c0;
        bus.outstate      = 3'b000;
        bus.doodle_y      = 10'd400;
        bus.doodle_rising = 1'b0;
        cyc(3);
        Reset = 1'b0;
        cyc(1);
        chk("rst_refresh_en", {31'd0, bus.refresh_en}, 32'd0);
        chk("rst_trigger", {31'd0, bus.trigger}, 32'd0);
        chk("rst_step", {31'd0, bus.scroll_step}, 32'd0);
        chk("rst_dy", {28'd0, bus.scroll_dy}, 32'd0);
        chk("rst_height", 32'(bus.height), 32'd0);

        // 1: y=100 -> 220 px as 27x8 + 4
        full_refresh(100, 28, 220, "t1");

        // 6: trigger is a level held through Refreshing, then released
        cyc(10);
        chk("t6_trigger_held", {31'd0, bus.trigger}, 32'd1);
        bus.outstate      = 3'b010;
        bus.doodle_y      = 10'd200;
        bus.doodle_rising = 1'b1;
        cyc(1);
        chk("t6_trigger_clear", {31'd0, bus.trigger}, 32'd0);
        cyc(3);
        chk("t6_no_rerequest", {31'd0, bus.refresh_en}, 32'd0);

        // 2: y=40 clamps to 240 px
        full_refresh(40, 30, 240, "t2");
        bus.outstate = 3'b010;
        cyc(2);

        // 3: pause after 5 steps aborts the scroll
        do_init();
        request(100);
        bus.outstate = 3'b100;
        cyc(1);
        push_steps(100, 5);
        c0 = step_cnt;
        for (int i = 0; i < 5; i++) ftick();
        bus.outstate = 3'b011;
        cyc(1);
        for (int i = 0; i < 3; i++) ftick();
        chk("t3_steps", 32'(step_cnt - c0), 32'd5);
        chk("t3_trigger", {31'd0, bus.trigger}, 32'd0);
        chk("t3_height", 32'(bus.height), 32'd40);

        // 4: back in IDLE -> re-arms, then game over drops the request
        request(100);
        chk("t4_rearm", {31'd0, bus.refresh_en}, 32'd1);
        bus.outstate = 3'b110;
        cyc(1);
        chk("t4_refresh_en_drop", {31'd0, bus.refresh_en}, 32'd0);
        c0 = step_cnt;
        for (int i = 0; i < 2; i++) ftick();
        chk("t4_no_steps", 32'(step_cnt - c0), 32'd0);
        chk("t4_height", 32'(bus.height), 32'd40);

        // 5: INIT mid-scroll clears everything
        do_init();
        request(100);
        bus.outstate = 3'b100;
        cyc(1);
        push_steps(100, 3);
        for (int i = 0; i < 3; i++) ftick();
        chk("t5_height_before", 32'(bus.height), 32'd24);
        bus.outstate = 3'b101;
        cyc(1);
        chk("t5_refresh_en", {31'd0, bus.refresh_en}, 32'd0);
        chk("t5_trigger", {31'd0, bus.trigger}, 32'd0);
        chk("t5_dy", {28'd0, bus.scroll_dy}, 32'd0);
        chk("t5_height", 32'(bus.height), 32'd0);
        bus.outstate = 3'b000;
        c0 = step_cnt;
        for (int i = 0; i < 2; i++) ftick();
        chk("t5_idle_ticks", 32'(step_cnt - c0), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
